vldrdy_stream_src: RTL and testbench

VLDRDY_STREAM_SRC -- requirements
Module: vldrdy_stream_src

---
 rtl/vldrdy_pkg.sv | 23 ++
 rtl/vldrdy_src_mem.sv | 36 +++
 rtl/vldrdy_stream_src.sv | 148 ++++++++++++++
 tb/tb_vldrdy_stream_src.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vldrdy_pkg.sv
// Shared types and elaboration-time checks for the valid/ready stream source.
// The legal PACK values are kept as a bit mask indexed by the PACK value.
package vldrdy_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Bit p is set when PACK=p is a supported words-per-beat value (1, 2, 4).
    localparam logic [4:0] PACK_LEGAL = 5'b10110;

    function automatic bit pack_is_legal(input int p);
        logic [2:0] idx;
        idx = p[2:0];
        return (p >= 0 && p <= 4) ? PACK_LEGAL[idx] : 1'b0;
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/vldrdy_src_mem.sv
// Word buffer for the stream source: flop array with one synchronous write
// port and PACK asynchronous read ports, so a whole beat is read in one cycle.
module vldrdy_src_mem
    import vldrdy_pkg::*;
#(
    parameter int WWIDTH = 8,
    parameter int DEPTH  = 32,
    parameter int PACK   = 1,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [WWIDTH-1:0]        wr_data,
    input  logic [PACK*AW-1:0]       rd_addr,
    output logic [PACK*WWIDTH-1:0]   rd_data
);

    logic [WWIDTH-1:0] mem [DEPTH];

    if (!is_pow2(DEPTH)) begin : g_bad_depth
        $error("vldrdy_src_mem: DEPTH must be a power of two");
    end

    // Contents are deliberately left unreset so a loaded pattern survives rst.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    for (genvar i = 0; i < PACK; i++) begin : g_rd
        assign rd_data[i*WWIDTH +: WWIDTH] = mem[rd_addr[i*AW +: AW]];
    end

endmodule

// File: rtl/vldrdy_stream_src.sv
// Plays a preloaded word buffer out on a valid/ready stream, PACK words per
// beat, either once (with a done pulse) or looping until told to stop.
module vldrdy_stream_src
    import vldrdy_pkg::*;
#(
    parameter int WWIDTH = 8,
    parameter int PACK   = 1,
    parameter int DEPTH  = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_en,
    input  logic                     start,
    input  logic                     loop,
    input  logic [AW:0]              len,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [WWIDTH-1:0]        wr_data,
    output logic                     dst_val,
    input  logic                     dst_rdy,
    output logic [WWIDTH*PACK-1:0]   dst_data,
    output logic                     dst_last,
    output logic                     busy,
    output logic                     done,
    output logic [15:0]              beat_cnt
);

    if (!pack_is_legal(PACK)) begin : g_bad_pack
        $error("vldrdy_stream_src: PACK must be 1, 2 or 4");
    end
    if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
        $error("vldrdy_stream_src: DEPTH must be a power of two and at least 4");
    end

    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0]   PACK_W  = (AW+1)'(PACK);
    localparam logic [AW+1:0] PACK_X  = (AW+2)'(PACK);

    state_t        state_q, state_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]   len_q, len_d;
    logic          loop_q, loop_d;
    logic          done_q, done_d;
    logic [15:0]   beat_cnt_q, beat_cnt_d;

    logic                    run;
    logic                    start_ok;
    logic                    accept;
    logic [AW+1:0]           ptr_end;
    logic [AW:0]             slot_idx [PACK];
    logic [PACK*AW-1:0]      rd_addr;
    logic [PACK*WWIDTH-1:0]  rd_words;

    vldrdy_src_mem #(
        .WWIDTH (WWIDTH),
        .DEPTH  (DEPTH),
        .PACK   (PACK)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en && (state_q == IDLE)),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_words)
    );

    assign run      = (state_q == RUN);
    assign start_ok = start && cfg_en && (len != '0) && (len <= DEPTH_W);
    assign ptr_end  = {1'b0, rd_ptr_q} + PACK_X;

    // dst_val is combinational on cfg_en so a disable takes effect at once.
    assign dst_val  = run && cfg_en;
    assign dst_last = run && (ptr_end >= {1'b0, len_q});
    assign accept   = dst_val && dst_rdy;
    assign busy     = run;
    assign done     = done_q;
    assign beat_cnt = beat_cnt_q;

    // Slot 0 lands in the MSBs; slots past the pass length read as zero.
    for (genvar i = 0; i < PACK; i++) begin : g_slot
        assign slot_idx[i]              = rd_ptr_q + (AW+1)'(i);
        assign rd_addr[i*AW +: AW]      = slot_idx[i][AW-1:0];
        assign dst_data[(PACK-1-i)*WWIDTH +: WWIDTH] =
            (run && (slot_idx[i] < len_q)) ? rd_words[i*WWIDTH +: WWIDTH] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rd_ptr_q   <= '0;
            len_q      <= '0;
            loop_q     <= 1'b0;
            done_q     <= 1'b0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            len_q      <= len_d;
            loop_q     <= loop_d;
            done_q     <= done_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        len_d      = len_q;
        loop_d     = loop_q;
        done_d     = 1'b0;
        beat_cnt_d = beat_cnt_q;

        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d  = RUN;
                    rd_ptr_d = '0;
                    len_d    = len;
                    loop_d   = loop;
                end
            end
            RUN: begin
                // A stop request only clears the loop flag; the pass in
                // flight still runs to its final beat.
                if (start && !loop) begin
                    loop_d = 1'b0;
                end
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + 16'd1;
                    if (dst_last) begin
                        rd_ptr_d = '0;
                        if (!loop_q) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        rd_ptr_d = rd_ptr_q + PACK_W;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_vldrdy_stream_src.sv
// Scoreboard bench: expected beats are queued when a pass is started and
// popped by per-instance monitors on every accepted beat.
module tb_vldrdy_stream_src;

    typedef struct {
        logic [15:0] data;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_en;
    logic        wr_en1, wr_en2;
    logic [4:0]  wr_addr;
    logic [7:0]  wr_data;

    logic        start1, loop1, val1, rdy1, last1, busy1, done1;
    logic [5:0]  len1;
    logic [7:0]  data1;
    logic [15:0] cnt1;

    logic        start2, loop2, val2, rdy2, last2, busy2, done2;
    logic [5:0]  len2;
    logic [15:0] data2;
    logic [15:0] cnt2;

    int    n_checks = 0;
    int    n_pass   = 0;
    int    acc1 = 0, acc2 = 0;
    time   t_first1 = 0, t_last1 = 0, t_last2 = 0;
    bit    rnd_rdy = 1'b0;
    bit    hold1 = 1'b0, hold2 = 1'b0;
    logic [7:0]  held1;
    logic [15:0] held2;
    logic [7:0]  model_mem [32];
    beat_t q1[$];
    beat_t q2[$];

    always #5 clk = ~clk;

    vldrdy_stream_src #(.WWIDTH(8), .PACK(1), .DEPTH(32)) dut1 (
        .clk(clk), .rst(rst), .cfg_en(cfg_en), .start(start1), .loop(loop1),
        .len(len1), .wr_en(wr_en1), .wr_addr(wr_addr), .wr_data(wr_data),
        .dst_val(val1), .dst_rdy(rdy1), .dst_data(data1), .dst_last(last1),
        .busy(busy1), .done(done1), .beat_cnt(cnt1)
    );

    vldrdy_stream_src #(.WWIDTH(8), .PACK(2), .DEPTH(32)) dut2 (
        .clk(clk), .rst(rst), .cfg_en(cfg_en), .start(start2), .loop(loop2),
        .len(len2), .wr_en(wr_en2), .wr_addr(wr_addr), .wr_data(wr_data),
        .dst_val(val2), .dst_rdy(rdy2), .dst_data(data2), .dst_last(last2),
        .busy(busy2), .done(done2), .beat_cnt(cnt2)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    // Reference beat: word b*pack is the MSB slot; words at or past n are zero.
    function automatic logic [15:0] model_beat(input int pack, input int n, input int b);
        logic [15:0] d = '0;
        for (int s = 0; s < pack; s++) begin
            int idx = b * pack + s;
            d = (d << 8) | ((idx < n) ? 16'(model_mem[idx]) : 16'h0);
        end
        return d;
    endfunction

    task automatic applyStimulus(input int which, input int n, input bit lp,
                                 input int passes, input bit expect_run);
        int pack = (which == 1) ? 1 : 2;
        int nb   = (n + pack - 1) / pack;
        beat_t e;
        if (expect_run) begin
            for (int p = 0; p < passes; p++) begin
                for (int b = 0; b < nb; b++) begin
                    e.data = model_beat(pack, n, b);
                    e.last = (b == nb - 1);
                    if (which == 1) q1.push_back(e); else q2.push_back(e);
                end
            end
        end
        @(posedge clk); #1;
        if (which == 1) begin start1 = 1'b1; len1 = 6'(n); loop1 = lp; end
        else            begin start2 = 1'b1; len2 = 6'(n); loop2 = lp; end
        @(posedge clk); #1;
        start1 = 1'b0;
        start2 = 1'b0;
        if (which == 1) begin
            if (expect_run) checkOutput("start_lat_val", val1, 1);
            else            checkOutput("start_ignored_busy", busy1, 0);
        end else begin
            checkOutput("start_lat_val2", val2, 1);
        end
    endtask

    task automatic waitAcc(input int n);
        int k = 0;
        while (acc1 < n && k < 500) begin
            @(negedge clk); #1;
            k++;
        end
        checkOutput("acc_wait_timeout", (acc1 >= n), 1);
    endtask

    task automatic waitDone(input int which);
        bit seen = 1'b0;
        for (int k = 0; k < 600 && !seen; k++) begin
            @(negedge clk); #1;
            seen = (which == 1) ? done1 : done2;
        end
        checkOutput("done_seen", seen, 1);
        if (seen) begin
            if (which == 1) begin
                checkOutput("done_latency", 32'(($time - 1 - t_last1) / 10), 1);
                checkOutput("val_dropped", val1, 0);
                checkOutput("queue_empty1", q1.size(), 0);
            end else begin
                checkOutput("done_latency2", 32'(($time - 1 - t_last2) / 10), 1);
                checkOutput("val_dropped2", val2, 0);
                checkOutput("queue_empty2", q2.size(), 0);
            end
            @(negedge clk); #1;
            checkOutput("done_one_cycle", (which == 1) ? done1 : done2, 0);
        end
    endtask

    // Random ready at about 30% duty while enabled.
    always @(posedge clk) begin
        if (rnd_rdy) begin
            #1;
            rdy1 = ($urandom_range(0, 99) < 30);
        end
    end

    always @(negedge clk) begin
        beat_t e;
        if (val1 && rdy1) begin
            if (q1.size() == 0) begin
                checkOutput("p1_extra_beat", 1, 0);
            end else begin
                e = q1.pop_front();
                checkOutput("p1_data", data1, e.data);
                checkOutput("p1_last", last1, e.last);
            end
            acc1++;
            if (acc1 == 1) t_first1 = $time;
            if (last1) t_last1 = $time;
        end
        if (hold1 && val1) checkOutput("p1_stall_stable", data1, held1);
        hold1 = val1 && !rdy1;
        held1 = data1;
    end

    always @(negedge clk) begin
        beat_t e;
        if (val2 && rdy2) begin
            if (q2.size() == 0) begin
                checkOutput("p2_extra_beat", 1, 0);
            end else begin
                e = q2.pop_front();
                checkOutput("p2_data", data2, e.data);
                checkOutput("p2_last", last2, e.last);
            end
            acc2++;
            if (last2) t_last2 = $time;
        end
        if (hold2 && val2) checkOutput("p2_stall_stable", data2, held2);
        hold2 = val2 && !rdy2;
        held2 = data2;
    end

    initial begin
        rst = 1'b1; cfg_en = 1'b1;
        wr_en1 = 1'b0; wr_en2 = 1'b0; wr_addr = '0; wr_data = '0;
        start1 = 1'b0; loop1 = 1'b0; len1 = '0; rdy1 = 1'b0;
        start2 = 1'b0; loop2 = 1'b0; len2 = '0; rdy2 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_val", val1, 0);
        checkOutput("rst_busy", busy1, 0);
        checkOutput("rst_done", done1, 0);
        checkOutput("rst_cnt", cnt1, 0);
        checkOutput("rst_data", data1, 0);
        checkOutput("rst_data2", data2, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 32; i++) begin
            @(posedge clk); #1;
            wr_en1 = 1'b1; wr_en2 = 1'b1;
            wr_addr = 5'(i); wr_data = 8'(i);
            model_mem[i] = 8'(i);
        end
        @(posedge clk); #1;
        wr_en1 = 1'b0; wr_en2 = 1'b0;
        rdy1 = 1'b1; rdy2 = 1'b1;

        // Starts that must be ignored: disabled, len=0, len above DEPTH.
        cfg_en = 1'b0;
        applyStimulus(1, 8, 0, 0, 0);
        cfg_en = 1'b1;
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 40, 0, 0, 0);

        // Full one-shot pass; a write issued while running must be dropped.
        applyStimulus(1, 32, 0, 1, 1);
        wr_en1 = 1'b1; wr_addr = 5'd2; wr_data = 8'hEE;
        @(posedge clk); #1;
        wr_en1 = 1'b0;
        waitDone(1);
        checkOutput("cnt_after_full", cnt1, 32);

        applyStimulus(1, 1, 0, 1, 1);
        waitDone(1);
        checkOutput("cnt_after_len1", cnt1, 33);

        rnd_rdy = 1'b1;
        applyStimulus(1, 32, 0, 1, 1);
        waitDone(1);
        rnd_rdy = 1'b0;
        rdy1 = 1'b1;
        checkOutput("cnt_after_random", cnt1, 65);

        // Loop of 4 words, stop requested after beat 6: ends after beat 8.
        acc1 = 0;
        applyStimulus(1, 4, 1, 2, 1);
        waitAcc(6);
        @(posedge clk); #1;
        start1 = 1'b1; loop1 = 1'b0;
        @(posedge clk); #1;
        start1 = 1'b0;
        waitDone(1);
        checkOutput("loop_no_bubble", 32'((t_last1 - t_first1) / 10), 7);
        checkOutput("cnt_after_loop", cnt1, 73);

        applyStimulus(2, 5, 0, 1, 1);
        waitDone(2);
        checkOutput("cnt2_after_pack2", cnt2, 3);

        // Disable mid-pass, resume, then reset mid-pass.
        acc1 = 0;
        applyStimulus(1, 32, 0, 1, 1);
        waitAcc(5);
        @(posedge clk); #1;
        cfg_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            checkOutput("disabled_val", val1, 0);
            checkOutput("disabled_busy", busy1, 1);
        end
        @(posedge clk); #1;
        cfg_en = 1'b1;
        waitAcc(10);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q1.delete();
        checkOutput("midrst_val", val1, 0);
        checkOutput("midrst_busy", busy1, 0);
        checkOutput("midrst_cnt", cnt1, 0);
        checkOutput("midrst_data", data1, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            checkOutput("midrst_no_done", done1, 0);
        end

        applyStimulus(1, 4, 0, 1, 1);
        waitDone(1);
        checkOutput("cnt_after_rst_pass", cnt1, 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
